// File: rtl/snn_pkg.sv
// Shared SNN definitions: datapath widths, default synaptic weight and the
// saturating accumulate used by the integrator and downstream neuron stages.
package snn_pkg;

  localparam int SYN_W_WIDTH = 8;
  localparam int CUR_WIDTH   = 8;
  localparam int ADD_WIDTH   = 16;

  localparam logic [SYN_W_WIDTH-1:0] DEFAULT_WEIGHT = 8'd64;
  localparam logic [CUR_WIDTH-1:0]   CUR_MAX        = '1;

  typedef struct packed {
    logic [CUR_WIDTH-1:0] value;
    logic                 clipped;
  } sat_add_t;

  // Reaching exactly CUR_MAX also counts as clipped.
  function automatic sat_add_t sat_add(input logic [CUR_WIDTH-1:0] base,
                                       input logic [ADD_WIDTH-1:0] addend);
    logic [ADD_WIDTH:0] total;
    sat_add_t           res;
    total = {{(ADD_WIDTH+1-CUR_WIDTH){1'b0}}, base} + {1'b0, addend};
    if (total >= {{(ADD_WIDTH+1-CUR_WIDTH){1'b0}}, CUR_MAX}) begin
      res.value   = CUR_MAX;
      res.clipped = 1'b1;
    end else begin
      res.value   = total[CUR_WIDTH-1:0];
      res.clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/synapse_integrator_if.sv
// Spike, weight-programming and current-output bundle of the synapse integrator.
interface synapse_integrator_if #(
  parameter int NSYN = 4,
  parameter int AW   = (NSYN > 1) ? $clog2(NSYN) : 1
);

  logic            en;
  logic [NSYN-1:0] spk_in;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_data;
  logic [7:0]      cur;
  logic            sat;

  modport master (output en, spk_in, w_we, w_addr, w_data,
                  input  cur, sat);

  modport slave  (input  en, spk_in, w_we, w_addr, w_data,
                  output cur, sat);

endinterface

// File: rtl/syn_weight_bank.sv
// NSYN x 8 synaptic weight register file: synchronous write, all entries
// visible in parallel, every entry restored to DEFAULT_W on reset.
module syn_weight_bank
  import snn_pkg::*;
#(
  parameter int                     NSYN      = 4,
  parameter int                     AW        = 2,
  parameter logic [SYN_W_WIDTH-1:0] DEFAULT_W = DEFAULT_WEIGHT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [AW-1:0]                    addr,
  input  logic [SYN_W_WIDTH-1:0]           data,
  output logic [NSYN-1:0][SYN_W_WIDTH-1:0] w
);

  logic [NSYN-1:0][SYN_W_WIDTH-1:0] w_q, w_d;

  // Matching only real indices makes out-of-range addresses a no-op.
  always_comb begin
    w_d = w_q;
    for (int i = 0; i < NSYN; i++) begin
      if (we && addr == i[AW-1:0]) begin
        w_d[i] = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      w_q <= {NSYN{DEFAULT_W}};
    end else begin
      w_q <= w_d;
    end
  end

  assign w = w_q;

endmodule

// File: rtl/synapse_integrator.sv
// Weighted spike integrator with shift-based leak feeding the LIF neuron's
// 8-bit current input; the trace saturates at 255 and flags the clip.
module synapse_integrator
  import snn_pkg::*;
#(
  parameter int                     NSYN        = 4,
  parameter int                     DECAY_SHIFT = 2,
  parameter int                     EDGE_MODE   = 1,
  parameter logic [SYN_W_WIDTH-1:0] DEFAULT_W   = DEFAULT_WEIGHT
) (
  input logic                 clk,
  input logic                 rst_n,
  synapse_integrator_if.slave bus
);

  localparam int AW    = (NSYN > 1) ? $clog2(NSYN) : 1;
  localparam int SUM_W = SYN_W_WIDTH + $clog2(NSYN) + 1;

  logic [NSYN-1:0][SYN_W_WIDTH-1:0] w;
  logic [NSYN-1:0]                  prev_q, prev_d, ev;
  logic [CUR_WIDTH-1:0]             cur_q, cur_d, leaked;
  logic                             sat_q, sat_d;
  logic [SUM_W-1:0]                 sum;
  sat_add_t                         upd;

  syn_weight_bank #(
    .NSYN      (NSYN),
    .AW        (AW),
    .DEFAULT_W (DEFAULT_W)
  ) u_weights (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.w_we),
    .addr  (bus.w_addr),
    .data  (bus.w_data),
    .w     (w)
  );

  // Weights are read before this edge's write lands, so a colliding spike sees the old value.
  always_comb begin
    ev = (EDGE_MODE != 0) ? (bus.spk_in & ~prev_q) : bus.spk_in;
    sum = '0;
    for (int i = 0; i < NSYN; i++) begin
      if (ev[i]) begin
        sum = sum + SUM_W'(w[i]);
      end
    end
    leaked = cur_q - (cur_q >> DECAY_SHIFT);
    upd    = sat_add(leaked, ADD_WIDTH'(sum));

    cur_d  = cur_q;
    sat_d  = sat_q;
    prev_d = prev_q;
    if (bus.en) begin
      cur_d  = upd.value;
      sat_d  = upd.clipped;
      prev_d = bus.spk_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur_q  <= '0;
      sat_q  <= 1'b0;
      prev_q <= '0;
    end else begin
      cur_q  <= cur_d;
      sat_q  <= sat_d;
      prev_q <= prev_d;
    end
  end

  assign bus.cur = cur_q;
  assign bus.sat = sat_q;

endmodule

// File: tb/tb_synapse_integrator.sv
// Scoreboard bench for synapse_integrator (NSYN=4, DECAY_SHIFT=2, EDGE_MODE=1):
// each driven cycle queues its hand-derived cur/sat, checked one edge later.
module tb_synapse_integrator;

  typedef struct {
    string      tag;
    logic [7:0] cur;
    logic       sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;
  exp_t expQ[$];

  synapse_integrator_if #(.NSYN(4)) bus ();

  synapse_integrator #(
    .NSYN        (4),
    .DECAY_SHIFT (2),
    .EDGE_MODE   (1),
    .DEFAULT_W   (8'd64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUT now shows.
  task automatic popAndCompare();
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_cur"}, int'(bus.cur), int'(e.cur));
      checkOutput({e.tag, "_sat"}, int'(bus.sat), int'(e.sat));
    end
  endtask

  // Drives one cycle of inputs, queues the result expected after the edge,
  // then samples 1 ns past the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic en,
                               input logic [3:0] spk, input logic we,
                               input logic [1:0] addr, input logic [7:0] data,
                               input logic [7:0] expCur, input logic expSat);
    exp_t e;
    rst_n      = rst;
    bus.en     = en;
    bus.spk_in = spk;
    bus.w_we   = we;
    bus.w_addr = addr;
    bus.w_data = data;
    e.tag = tag;
    e.cur = expCur;
    e.sat = expSat;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare();
  endtask

  initial begin
    int decay[13];
    decay = '{48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 3};
    testsRun   = 0;
    failCount  = 0;
    rst_n      = 1'b1;
    bus.en     = 1'b0;
    bus.spk_in = '0;
    bus.w_we   = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    @(negedge clk);

    // Reset, then idle with enable high.
    applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus("idle", 0, 1, 4'h0, 0, 0, 0, 0, 0);

    // Each synapse holds the default weight of 64.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("w%0d_default", i), 0, 1, 4'(1 << i), 0, 0, 0, 64, 0);
      applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    end

    // A held-high spike triggers once, then leaks down to the floor of 3.
    applyStimulus("edge0", 0, 1, 4'b0001, 0, 0, 0, 64, 0);
    for (int i = 0; i < 13; i++) applyStimulus($sformatf("decay%0d", i), 0, 1, 4'b0001, 0, 0, 0, 8'(decay[i]), 0);

    // Write to w1 in the same cycle as its spike: old weight used, new one afterwards.
    applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    applyStimulus("collide", 0, 1, 4'b0010, 1, 1, 8'd10, 64, 0);
    for (int i = 0; i < 13; i++) applyStimulus($sformatf("cdecay%0d", i), 0, 1, 4'b0000, 0, 0, 0, 8'(decay[i]), 0);
    applyStimulus("w1_new", 0, 1, 4'b0010, 0, 0, 0, 13, 0);
    applyStimulus("w1_held", 0, 1, 4'b0010, 0, 0, 0, 10, 0);

    // Saturation: landing exactly on 255 clips, larger sums clip, sat holds when disabled.
    applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    applyStimulus("wr_w0_255", 0, 0, 4'h0, 1, 0, 8'd255, 0, 0);
    applyStimulus("exact255", 0, 1, 4'b0001, 0, 0, 0, 255, 1);
    applyStimulus("leak255", 0, 1, 4'h0, 0, 0, 0, 192, 0);
    for (int i = 0; i < 4; i++) applyStimulus("wr200", 0, 0, 4'h0, 1, 2'(i), 8'd200, 192, 0);
    applyStimulus("sat_all", 0, 1, 4'hF, 0, 0, 0, 255, 1);
    applyStimulus("unsat", 0, 1, 4'h0, 0, 0, 0, 192, 0);
    applyStimulus("resat", 0, 1, 4'hF, 0, 0, 0, 255, 1);
    applyStimulus("sat_hold", 0, 0, 4'h0, 0, 0, 0, 255, 1);

    // Enable gating: trace and spike history freeze while en is low.
    applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    applyStimulus("g_a", 0, 1, 4'b0010, 0, 0, 0, 64, 0);
    applyStimulus("g_b", 0, 1, 4'b0000, 0, 0, 0, 48, 0);
    applyStimulus("g_c", 0, 1, 4'b0100, 0, 0, 0, 100, 0);
    for (int k = 0; k < 5; k++) applyStimulus("gated", 0, 0, (k % 2 == 0) ? 4'hF : 4'h0, 0, 0, 0, 100, 0);
    applyStimulus("ungated", 0, 1, 4'h0, 0, 0, 0, 75, 0);
    applyStimulus("gated_f", 0, 0, 4'hF, 0, 0, 0, 75, 0);
    applyStimulus("edge_en", 0, 1, 4'hF, 0, 0, 0, 255, 1);
    applyStimulus("held_f", 0, 1, 4'hF, 0, 0, 0, 192, 0);

    // Reset mid-trace discards the trace, history and programmed weights.
    applyStimulus("reset", 1, 1, 4'h0, 0, 0, 0, 0, 0);
    applyStimulus("m_wr_w0", 0, 0, 4'h0, 1, 0, 8'd180, 0, 0);
    applyStimulus("m_180", 0, 1, 4'b0001, 1, 2, 8'd7, 180, 0);
    applyStimulus("m_rst", 1, 1, 4'hF, 1, 2, 8'd99, 0, 0);
    applyStimulus("m_sat", 0, 1, 4'hF, 0, 0, 0, 255, 1);
    applyStimulus("m_idle", 0, 1, 4'h0, 0, 0, 0, 192, 0);
    applyStimulus("m_w2", 0, 1, 4'b0100, 0, 0, 0, 208, 0);
    applyStimulus("m_w0", 0, 1, 4'b0001, 0, 0, 0, 220, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/synapse_integrator.md
Name: synapse_integrator

Overview:
- Upstream stage of the leaky integrate-and-fire (LIF) neuron; produces the neuron's 8-bit input current each clock.
- Takes NSYN presynaptic spike lines, typically outputs of other neurons, and weights each line with a programmable 8-bit synaptic weight.
- Integrates the weighted spikes into a leaky current trace with shift-based decay, saturating at 255.
- Output `cur` wires directly to the neuron's current input; `en` is shared with the neuron's enable.

Parameters:
- NSYN, 4, number of synapse inputs (1..8); fixes w_addr width as clog2(NSYN), min 1.
- DECAY_SHIFT, 2, leak = cur >> DECAY_SHIFT per enabled cycle; legal range 1..7.
- EDGE_MODE, 1, 1 = only rising edges of spk_in contribute; 0 = level (every high cycle contributes).
- DEFAULT_W, 8'd64, weight value loaded into every synapse on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1), codebase port name.
- en  in  1  integration enable; low = hold trace.
- spk_in  in  NSYN  presynaptic spike lines, synchronous to clk.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(NSYN)  synapse index for write.
- w_data  in  8  weight value to write.
- cur  out  8  synaptic current to neuron.
- sat  out  1  registered; high for the cycle after an update that clipped at 255.

Behaviour:
- One clock; reset is synchronous and active-high. rst_n=1 at a clk edge: cur=0, sat=0, all weights=DEFAULT_W, spike-history register=0. Reset overrides en and w_we in the same cycle.
- Reset mid-operation: the trace is discarded immediately; cur=0 on the cycle after the reset edge.
- Event vector:
  - EDGE_MODE=1: ev[i] = spk_in[i] & ~prev[i].
  - EDGE_MODE=0: ev[i] = spk_in[i].
- Weighted sum: S = sum of w[i] over all i with ev[i]=1. Compute at width 8+clog2(NSYN)+1; no truncation.
- Update when en=1 and not reset: nxt = cur - (cur >> DECAY_SHIFT) + S.
  - nxt >= 255: cur <= 255, sat <= 1.
  - Otherwise: cur <= nxt, sat <= 0.
  - Leak is always <= cur, so no underflow. For cur < 2^DECAY_SHIFT the leak is 0 and the value holds; this floor is intentional.
- en=0: cur, sat and prev hold. Spike edges are detected only across enabled cycles.
- prev <= spk_in on every enabled cycle, including cycles where the spike has no effect.
- Latency: a spike sampled at edge k appears in cur after edge k (one cycle). The neuron consumes it on edge k+1.
- Weight write: when w_we=1 (independent of en), w[w_addr] <= w_data at the edge.
  - Same-cycle write and spike on that synapse: the OLD weight is used.
  - Addresses >= NSYN are ignored; no state changes.
- Weight 0 disables a synapse. Weight writes are not blocked during saturation.
- No combinational path from any input to cur or sat; both are flops.

Decomposition:
- Shared package (snn_pkg):
  - SYN_W_WIDTH=8 and CUR_WIDTH=8.
  - Common default weight.
  - Function computing the saturating add.
  - Reused by the LIF neuron and later network tiles.
- One sub-module: syn_weight_bank, an NSYN x 8 register file.
  - Synchronous write, asynchronous read of all entries.
  - Reset to DEFAULT_W.
  - The integrator datapath stays in synapse_integrator.

Test Plan:
1. Reset then idle: rst_n=1 one cycle, en=1, spk_in=0 -> cur=0, sat=0 for 10 cycles; reads confirm all weights 64.
2. Single edge, EDGE_MODE=1, DECAY_SHIFT=2: spk_in[0] rises and stays high -> cur sequence 64, 48, 36, 27, 21, ... (no re-trigger while held high).
3. Saturation: write w0..w3=200, pulse all four -> cur=255, sat=1 next cycle. Following idle cycle -> cur=192, sat=0.
4. Write/spike collision: w_we=1, w_addr=1, w_data=10 in the same cycle as a spk_in[1] rising edge (old w1=64) -> cur=64. Next rising edge on spk_in[1] from cur=0 -> adds 10.
5. Enable gating: cur=100, en=0 for 5 cycles with spikes toggling -> cur stays 100. en=1, no spikes -> 75.
6. Reset mid-trace: cur=180 and w2=7; assert rst_n with en=1 and spk_in=4'hF -> cur=0 next cycle, w2=64. First enabled cycle after release with spk_in still 4'hF (prev cleared) -> cur=255, sat=1.
